// File: rtl/verin_ctrl_pkg.sv
// Shared types and register layout for the tiller actuator controller.
package verin_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_BRAKE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] REG_ANGLE    = 2'd0;
  localparam logic [1:0] REG_SETPOINT = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int unsigned CTRL_RUN_BIT = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;
  localparam int unsigned CTRL_DB_LSB  = 16;
  localparam int unsigned CTRL_DB_MSB  = 27;
  localparam int unsigned DB_W         = CTRL_DB_MSB - CTRL_DB_LSB + 1;

  // STATUS word as seen on the bus
  typedef struct packed {
    logic [24:0] rsvd_hi;
    logic        limit_flag;
    logic        timeout_flag;
    logic        at_target;
    logic [1:0]  rsvd_lo;
    logic [1:0]  state;
  } status_t;

endpackage

// File: rtl/verin_angle_sampler.sv
// Angle input synchronizer, sample divider, sampled-angle register and eval pulse.
module verin_angle_sampler
  import verin_ctrl_pkg::*;
#(
  parameter int unsigned ANGLE_W    = 12,
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ANGLE_W-1:0] angle_in,
  output logic [ANGLE_W-1:0] angle_sample,
  output logic               eval
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [ANGLE_W-1:0] sync1_q, sync1_d;
  logic [ANGLE_W-1:0] sync2_q, sync2_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               eval_q, eval_d;
  logic               tick_c;

  assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    sync1_d = angle_in;
    sync2_d = sync1_q;
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    angle_d = tick_c ? sync2_q : angle_q;
    eval_d  = tick_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      angle_q <= '0;
      eval_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      angle_q <= angle_d;
      eval_q  <= eval_d;
    end
  end

  assign angle_sample = angle_q;
  assign eval         = eval_q;

endmodule

// File: rtl/verin_angle_ctrl.sv
// Closed-loop tiller actuator controller with Avalon-MM register slave.
// Optional end-stop limit checking is built when VERIN_LIMIT_CHECK_EN is defined.
module verin_angle_ctrl
  import verin_ctrl_pkg::*;
#(
  parameter int unsigned        ANGLE_W       = 12,
  parameter int unsigned        SAMPLE_DIV    = 50000,
  parameter int unsigned        DEADTIME      = 5000,
  parameter int unsigned        TIMEOUT_TICKS = 200,
  parameter int unsigned        DEADBAND_RST  = 8,
  parameter logic [ANGLE_W-1:0] ANGLE_MIN     = 'h080,
  parameter logic [ANGLE_W-1:0] ANGLE_MAX     = 'hF80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [ANGLE_W-1:0] angle_in,
  output logic               motor_en,
  output logic               motor_dir,
  output logic               fault_irq
);

  localparam int unsigned ERR_W = ANGLE_W + 1;
  localparam int unsigned CMP_W = (ERR_W > DB_W) ? ERR_W : DB_W;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned DT_W  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  logic [ANGLE_W-1:0] angle_q;
  logic               eval;

  verin_angle_sampler #(
    .ANGLE_W    (ANGLE_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .angle_in     (angle_in),
    .angle_sample (angle_q),
    .eval         (eval)
  );

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] setpoint_q, setpoint_d;
  logic               run_q, run_d;
  logic [DB_W-1:0]    deadband_q, deadband_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [DT_W-1:0]    dt_cnt_q, dt_cnt_d;
  logic               at_target_q, at_target_d;
  logic               timeout_flag_q, timeout_flag_d;
  logic               limit_flag_q, limit_flag_d;
  logic               motor_en_q, motor_en_d;
  logic               motor_dir_q, motor_dir_d;
  logic               fault_irq_q, fault_irq_d;
  logic [31:0]        readdata_q, readdata_d;

  logic               wr_ctrl_c, clr_c;
  logic signed [ERR_W-1:0] err_c;
  logic [ERR_W-1:0]   mag_c;
  logic               in_band_c, err_pos_c, err_neg_c, overshoot_c;
  logic [TO_W-1:0]    to_inc_c;
  logic               limit_hit_c, limit_block_c;
  logic               wdata_unused_c;
  status_t            status_c;

  assign wr_ctrl_c      = write && (address == REG_CTRL);
  assign clr_c          = wr_ctrl_c && writedata[CTRL_CLR_BIT];
  assign wdata_unused_c = ^writedata;

  // Signed error and deadband test
  assign err_c       = $signed({1'b0, setpoint_q}) - $signed({1'b0, angle_q});
  assign mag_c       = err_c[ERR_W-1] ? ERR_W'(-err_c) : ERR_W'(err_c);
  assign in_band_c   = (CMP_W'(mag_c) <= CMP_W'(deadband_q));
  assign err_neg_c   = err_c[ERR_W-1];
  assign err_pos_c   = !err_c[ERR_W-1] && (err_c != '0);
  assign overshoot_c = motor_dir_q ? err_neg_c : err_pos_c;
  assign to_inc_c    = (to_cnt_q == TO_W'(TIMEOUT_TICKS)) ? to_cnt_q : to_cnt_q + TO_W'(1);

`ifdef VERIN_LIMIT_CHECK_EN
  assign limit_hit_c   = (state_q == ST_MOVE) &&
                         ((motor_dir_q && (angle_q > ANGLE_MAX)) ||
                          (!motor_dir_q && (angle_q < ANGLE_MIN)));
  assign limit_block_c = (err_pos_c && (angle_q > ANGLE_MAX)) ||
                         (!err_pos_c && (angle_q < ANGLE_MIN));
`else
  logic limit_unused_c;
  assign limit_hit_c    = 1'b0;
  assign limit_block_c  = 1'b0;
  assign limit_unused_c = ^{ANGLE_MIN, ANGLE_MAX};
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (eval && run_q && !in_band_c && !limit_block_c) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (limit_hit_c)                                 state_d = ST_FAULT;
        else if (eval && (in_band_c || overshoot_c))     state_d = ST_BRAKE;
        else if (!run_q)                                 state_d = ST_BRAKE;
        else if (eval && (to_inc_c == TO_W'(TIMEOUT_TICKS))) state_d = ST_FAULT;
      end
      ST_BRAKE: begin
        if (dt_cnt_q == DT_W'(DEADTIME - 1)) state_d = ST_IDLE;
      end
      default: begin
        if (clr_c) state_d = ST_IDLE;
      end
    endcase
  end

  // Counters, flags and registered outputs follow the next state
  always_comb begin
    to_cnt_d       = to_cnt_q;
    dt_cnt_d       = dt_cnt_q;
    at_target_d    = at_target_q;
    timeout_flag_d = timeout_flag_q;
    limit_flag_d   = limit_flag_q;
    motor_dir_d    = motor_dir_q;

    if (state_q == ST_MOVE && eval) to_cnt_d = to_inc_c;
    if (state_q == ST_IDLE && state_d == ST_MOVE) begin
      to_cnt_d    = '0;
      motor_dir_d = err_pos_c;
    end

    if (state_q == ST_BRAKE)                           dt_cnt_d = dt_cnt_q + DT_W'(1);
    if (state_q != ST_BRAKE && state_d == ST_BRAKE)    dt_cnt_d = '0;

    if (state_q == ST_IDLE && eval) at_target_d = in_band_c;
    if (state_q == ST_MOVE && state_d == ST_BRAKE && eval && in_band_c) at_target_d = 1'b1;

    if (clr_c) begin
      timeout_flag_d = 1'b0;
      limit_flag_d   = 1'b0;
    end
    if (state_q == ST_MOVE && state_d == ST_FAULT) begin
      if (limit_hit_c) limit_flag_d   = 1'b1;
      else             timeout_flag_d = 1'b1;
    end

    motor_en_d  = (state_d == ST_MOVE);
    fault_irq_d = (state_d == ST_FAULT);
  end

  // Software registers
  always_comb begin
    setpoint_d = setpoint_q;
    run_d      = run_q;
    deadband_d = deadband_q;
    if (write && address == REG_SETPOINT) setpoint_d = writedata[ANGLE_W-1:0];
    if (wr_ctrl_c) begin
      run_d      = writedata[CTRL_RUN_BIT];
      deadband_d = writedata[CTRL_DB_MSB:CTRL_DB_LSB];
    end
  end

  always_comb begin
    status_c              = '0;
    status_c.state        = state_q;
    status_c.at_target    = at_target_q;
    status_c.timeout_flag = timeout_flag_q;
    status_c.limit_flag   = limit_flag_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      REG_ANGLE:    readdata_d = 32'(angle_q);
      REG_SETPOINT: readdata_d = 32'(setpoint_q);
      REG_CTRL: begin
        readdata_d[CTRL_DB_MSB:CTRL_DB_LSB] = deadband_q;
        readdata_d[CTRL_RUN_BIT]            = run_q;
      end
      default:      readdata_d = status_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      setpoint_q     <= '0;
      run_q          <= 1'b0;
      deadband_q     <= DB_W'(DEADBAND_RST);
      to_cnt_q       <= '0;
      dt_cnt_q       <= '0;
      at_target_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
      limit_flag_q   <= 1'b0;
      motor_en_q     <= 1'b0;
      motor_dir_q    <= 1'b0;
      fault_irq_q    <= 1'b0;
      readdata_q     <= '0;
    end else begin
      setpoint_q     <= setpoint_d;
      run_q          <= run_d;
      deadband_q     <= deadband_d;
      to_cnt_q       <= to_cnt_d;
      dt_cnt_q       <= dt_cnt_d;
      at_target_q    <= at_target_d;
      timeout_flag_q <= timeout_flag_d;
      limit_flag_q   <= limit_flag_d;
      motor_en_q     <= motor_en_d;
      motor_dir_q    <= motor_dir_d;
      fault_irq_q    <= fault_irq_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign motor_en  = motor_en_q;
  assign motor_dir = motor_dir_q;
  assign fault_irq = fault_irq_q;

endmodule

// File: tb/tb_verin_angle_ctrl.sv
// Directed bench for verin_angle_ctrl with a short sample period and dead time.
module tb_verin_angle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [11:0] angle_in;
  logic        motor_en;
  logic        motor_dir;
  logic        fault_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  verin_angle_ctrl #(
    .ANGLE_W       (12),
    .SAMPLE_DIV    (4),
    .DEADTIME      (3),
    .TIMEOUT_TICKS (5),
    .DEADBAND_RST  (2),
    .ANGLE_MIN     (12'h080),
    .ANGLE_MAX     (12'hF80)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .angle_in  (angle_in),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .fault_irq (fault_irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    writedata = '0;
    address   = 2'd3;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 d = readdata;
    address = 2'd3;
  endtask

  task automatic wait_motor(input logic lvl, input int budget);
    int w = 0;
    while (motor_en !== lvl && w < budget) begin
      @(posedge clk);
      #1 w++;
    end
  endtask

  // Number of consecutive samples with motor_en at lvl, starting now
  task automatic motor_run(input logic lvl, input int budget, output int n);
    n = 0;
    while (motor_en === lvl && n < budget) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for STATUS.state == st, then counts how many cycles it stays there
  task automatic state_run(input logic [1:0] st, input int budget, output int n);
    int w = 0;
    n = 0;
    while (readdata[1:0] !== st && w < budget) begin
      @(posedge clk);
      #1 w++;
    end
    while (readdata[1:0] === st && n < budget) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;

    reset     = 1'b1;
    address   = 2'd3;
    write     = 1'b0;
    writedata = '0;
    angle_in  = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_motor_en", 32'(motor_en), 32'd0);
    check_eq("rst_motor_dir", 32'(motor_dir), 32'd0);
    check_eq("rst_fault_irq", 32'(fault_irq), 32'd0);
    bus_read(2'd3, rd); check_eq("rst_status", rd, 32'h0000_0000);
    bus_read(2'd0, rd); check_eq("rst_angle", rd, 32'h0000_0000);
    bus_read(2'd1, rd); check_eq("rst_setpoint", rd, 32'h0000_0000);
    bus_read(2'd2, rd); check_eq("rst_ctrl", rd, 32'h0002_0000);

    // Extend toward setpoint, then settle inside the deadband
    angle_in = 12'h100;
    bus_write(2'd1, 32'h0000_0200);
    bus_write(2'd2, 32'h0002_0001);
    wait_motor(1'b1, 40);
    check_eq("move_en", 32'(motor_en), 32'd1);
    check_eq("move_dir", 32'(motor_dir), 32'd1);
    bus_read(2'd3, rd); check_eq("move_status", rd, 32'h0000_0001);
    angle_in = 12'h1FF;
    state_run(2'd2, 40, n);
    check_eq("brake_len", 32'(n), 32'd3);
    bus_read(2'd3, rd); check_eq("settled_status", rd, 32'h0000_0010);
    check_eq("settled_en", 32'(motor_en), 32'd0);

    // Stalled actuator: timeout after five sample ticks in MOVE
    bus_write(2'd2, 32'h0002_0000);
    angle_in = 12'h100;
    bus_write(2'd1, 32'h0000_0300);
    repeat (12) @(posedge clk);
    bus_write(2'd2, 32'h0002_0001);
    wait_motor(1'b1, 40);
    check_eq("to_move_en", 32'(motor_en), 32'd1);
    motor_run(1'b1, 60, n);
    check_eq("to_move_len", 32'(n), 32'd20);
    check_eq("to_fault_irq", 32'(fault_irq), 32'd1);
    check_eq("to_fault_en", 32'(motor_en), 32'd0);
    bus_read(2'd3, rd); check_eq("to_status", rd, 32'h0000_0023);
    bus_write(2'd2, 32'h0002_0002);
    bus_read(2'd3, rd); check_eq("clr_status", rd, 32'h0000_0000);
    check_eq("clr_fault_irq", 32'(fault_irq), 32'd0);
    bus_read(2'd2, rd); check_eq("clr_ctrl", rd, 32'h0002_0000);

    // Overshoot: extend, jump past the target, brake, retract
    bus_write(2'd1, 32'h0000_0200);
    bus_write(2'd2, 32'h0002_0001);
    wait_motor(1'b1, 40);
    check_eq("os_dir_up", 32'(motor_dir), 32'd1);
    angle_in = 12'h210;
    motor_run(1'b1, 40, n);
    check_eq("os_dir_held", 32'(motor_dir), 32'd1);
    motor_run(1'b0, 40, n);
    check_eq("os_gap", 32'(n), 32'd4);
    check_eq("os_reentry_en", 32'(motor_en), 32'd1);
    check_eq("os_dir_down", 32'(motor_dir), 32'd0);

    // run cleared while moving
    bus_write(2'd2, 32'h0002_0000);
    check_eq("stop_write_edge", 32'(motor_en), 32'd1);
    @(posedge clk);
    #1 check_eq("stop_next_cycle", 32'(motor_en), 32'd0);
    state_run(2'd2, 20, n);
    check_eq("stop_brake_len", 32'(n), 32'd3);
    bus_read(2'd3, rd); check_eq("stop_status", rd, 32'h0000_0000);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 if (motor_en === 1'b1) n++;
    end
    check_eq("stop_no_move", 32'(n), 32'd0);
    bus_write(2'd2, 32'h0002_0001);
    wait_motor(1'b1, 20);
    check_eq("rerun_en", 32'(motor_en), 32'd1);
    check_eq("rerun_dir", 32'(motor_dir), 32'd0);
    bus_write(2'd2, 32'h0002_0000);
    wait_motor(1'b0, 20);

    // Travel past the upper end-stop
    angle_in = 12'hF00;
    bus_write(2'd1, 32'h0000_0FF0);
    repeat (12) @(posedge clk);
    bus_write(2'd2, 32'h0002_0001);
    wait_motor(1'b1, 40);
    check_eq("lim_move_en", 32'(motor_en), 32'd1);
    angle_in = 12'hF90;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
`ifdef VERIN_LIMIT_CHECK_EN
    check_eq("lim_fault_irq", 32'(fault_irq), 32'd1);
    check_eq("lim_motor_en", 32'(motor_en), 32'd0);
    bus_read(2'd3, rd); check_eq("lim_status", rd, 32'h0000_0043);
`else
    check_eq("nolim_still_en", 32'(motor_en), 32'd1);
    bus_read(2'd3, rd); check_eq("nolim_status", rd, 32'h0000_0001);
    angle_in = 12'hFEF;
    wait_motor(1'b0, 40);
    check_eq("nolim_stop_en", 32'(motor_en), 32'd0);
    check_eq("nolim_fault_irq", 32'(fault_irq), 32'd0);
    repeat (10) @(posedge clk);
    bus_read(2'd3, rd); check_eq("nolim_status_done", rd, 32'h0000_0010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
